// File: rtl/key_adj_pulse.sv
// key_adj_pulse
// Turns the raw hour/minute push-buttons of a clock display into clean
// adjust pulses. Each key is synchronized, debounced against the 1 kHz
// tick and produces one CP-wide pulse per confirmed press. When the macro
// KEY_AUTO_REPEAT_EN is defined, a key held for REPEAT_DLY_MS ticks after
// its first pulse also auto-repeats every REPEAT_MS ticks. When the macro
// is undefined, each press gives exactly one pulse.
//
// Ports
//   CP        in   system clock, rising edge
//   CR        in   asynchronous active-high reset
//   Tick1k    in   1 kHz strobe, one CP cycle wide
//   KeyHr_n   in   raw hour key, active-low, asynchronous
//   KeyMin_n  in   raw minute key, active-low, asynchronous
//   AdjHr     out  one-cycle hour increment pulse
//   AdjMin    out  one-cycle minute increment pulse
//   Held      out  high while either key is PRESSED or REPEAT
//
// Per-key FSM
//   state    | meaning
//   IDLE     | key released, waiting for a low level
//   DB_PRESS | key low, counting ticks to confirm the press
//   PRESSED  | press confirmed and pulsed, waiting for release/repeat delay
//   REPEAT   | auto-repeating (KEY_AUTO_REPEAT_EN only)
//   DB_REL   | key high, counting ticks to confirm the release

module key_adj_pulse #(
  parameter int DEBOUNCE_MS   = 20,
  parameter int REPEAT_DLY_MS = 500,
  parameter int REPEAT_MS     = 100
) (
  input  logic CP,
  input  logic CR,
  input  logic Tick1k,
  input  logic KeyHr_n,
  input  logic KeyMin_n,
  output logic AdjHr,
  output logic AdjMin,
  output logic Held
);

  // Counter is wide enough for the largest threshold, never below 10 bits.
  localparam int MAX_AB = (DEBOUNCE_MS > REPEAT_DLY_MS) ? DEBOUNCE_MS : REPEAT_DLY_MS;
  localparam int MAX_MS = (MAX_AB > REPEAT_MS) ? MAX_AB : REPEAT_MS;
  localparam int CW     = ($clog2(MAX_MS + 1) > 10) ? $clog2(MAX_MS + 1) : 10;

  localparam logic [CW-1:0] DB_N  = CW'(DEBOUNCE_MS);
`ifdef KEY_AUTO_REPEAT_EN
  localparam logic [CW-1:0] DLY_N = CW'(REPEAT_DLY_MS);
  localparam logic [CW-1:0] RPT_N = CW'(REPEAT_MS);
`endif

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    DB_PRESS = 3'd1,
    PRESSED  = 3'd2,
    DB_REL   = 3'd3
`ifdef KEY_AUTO_REPEAT_EN
    ,
    REPEAT   = 3'd4
`endif
  } state_t;

  // Index 0 = hour key, index 1 = minute key.
  logic [1:0] key_raw;
  logic [1:0] sync1;
  logic [1:0] sync2;
  logic [1:0] adj;
  logic [1:0] held_k;

  assign key_raw = {KeyMin_n, KeyHr_n};

  // Synchronizer flops reset to the released level so a key held through
  // reset is seen as a fresh press once reset is removed.
  always_ff @(posedge CP or posedge CR) begin
    if (CR) begin
      sync1 <= 2'b11;
      sync2 <= 2'b11;
    end else begin
      sync1 <= key_raw;
      sync2 <= sync1;
    end
  end

  for (genvar g = 0; g < 2; g++) begin : g_key
    state_t        state;
    state_t        state_nxt;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_nxt;
    logic [CW-1:0] cnt_inc;
    logic [CW-1:0] cnt_new;
    logic          key_n;
    logic          pulse_req;
    logic          adj_q;
    logic          held_s;
`ifdef KEY_AUTO_REPEAT_EN
    logic          from_rep;
    logic          from_rep_nxt;
`endif

    assign key_n = sync2[g];

    // Saturating advance in the current state; on any state change the
    // count restarts, but a tick in that same cycle already counts.
    assign cnt_inc = (Tick1k && (cnt != {CW{1'b1}})) ? cnt + CW'(1) : cnt;
    assign cnt_new = Tick1k ? CW'(1) : '0;

    always_ff @(posedge CP or posedge CR) begin
      if (CR) begin
        state    <= IDLE;
        cnt      <= '0;
        adj_q    <= 1'b0;
`ifdef KEY_AUTO_REPEAT_EN
        from_rep <= 1'b0;
`endif
      end else begin
        state    <= state_nxt;
        cnt      <= cnt_nxt;
        adj_q    <= pulse_req;
`ifdef KEY_AUTO_REPEAT_EN
        from_rep <= from_rep_nxt;
`endif
      end
    end

    always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt_inc;
`ifdef KEY_AUTO_REPEAT_EN
      from_rep_nxt = from_rep;
`endif
      case (state)
        IDLE: begin
          cnt_nxt = '0;
          if (!key_n) begin
            state_nxt = DB_PRESS;
            cnt_nxt   = cnt_new;
          end
        end
        DB_PRESS: begin
          if (key_n) begin
            state_nxt = IDLE;
            cnt_nxt   = '0;
          end else if (cnt >= DB_N) begin
            state_nxt = PRESSED;
            cnt_nxt   = cnt_new;
          end
        end
        PRESSED: begin
          if (key_n) begin
            state_nxt = DB_REL;
            cnt_nxt   = cnt_new;
`ifdef KEY_AUTO_REPEAT_EN
            from_rep_nxt = 1'b0;
          end else if (cnt >= DLY_N) begin
            state_nxt = REPEAT;
            cnt_nxt   = cnt_new;
`endif
          end
        end
`ifdef KEY_AUTO_REPEAT_EN
        REPEAT: begin
          if (key_n) begin
            state_nxt    = DB_REL;
            cnt_nxt      = cnt_new;
            from_rep_nxt = 1'b1;
          end else if (cnt >= RPT_N) begin
            cnt_nxt = cnt_new;
          end
        end
`endif
        DB_REL: begin
          if (!key_n) begin
            // A bounce back to low resumes the held state without a pulse.
`ifdef KEY_AUTO_REPEAT_EN
            state_nxt = from_rep ? REPEAT : PRESSED;
`else
            state_nxt = PRESSED;
`endif
            cnt_nxt   = cnt_new;
          end else if (cnt >= DB_N) begin
            state_nxt = IDLE;
            cnt_nxt   = '0;
          end
        end
        default: begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end
      endcase
    end

    always_comb begin
      pulse_req = 1'b0;
      held_s    = 1'b0;
      case (state)
        DB_PRESS: pulse_req = !key_n && (cnt >= DB_N);
        PRESSED: begin
          held_s = 1'b1;
`ifdef KEY_AUTO_REPEAT_EN
          pulse_req = !key_n && (cnt >= DLY_N);
`endif
        end
`ifdef KEY_AUTO_REPEAT_EN
        REPEAT: begin
          held_s    = 1'b1;
          pulse_req = !key_n && (cnt >= RPT_N);
        end
`endif
        default: begin
          pulse_req = 1'b0;
          held_s    = 1'b0;
        end
      endcase
    end

    assign adj[g]    = adj_q;
    assign held_k[g] = held_s;
  end

  assign AdjHr  = adj[0];
  assign AdjMin = adj[1];
  assign Held   = |held_k;

endmodule

// File: tb/tb_key_adj_pulse.sv
// Testbench for key_adj_pulse with default parameters and Tick1k every
// 10 CP. Expected pulse tick numbers are queued when a key is driven and
// checked when the DUT pulses. Repeat pulses are expected only when
// KEY_AUTO_REPEAT_EN is defined for the build.

module tb_key_adj_pulse;

  logic CP;
  logic CR;
  logic Tick1k;
  logic KeyHr_n;
  logic KeyMin_n;
  logic AdjHr;
  logic AdjMin;
  logic Held;

  int total = 0;
  int bad   = 0;
  int tk    = 0;
  int cyc   = 0;
  int hr_cyc  = -1;
  int min_cyc = -2;
  int prev_hr  = 0;
  int prev_min = 0;
  logic tick_en = 1'b1;
  int div = 0;

  int exp_hr[$];
  int exp_min[$];

  key_adj_pulse #(
    .DEBOUNCE_MS  (20),
    .REPEAT_DLY_MS(500),
    .REPEAT_MS    (100)
  ) dut (
    .CP      (CP),
    .CR      (CR),
    .Tick1k  (Tick1k),
    .KeyHr_n (KeyHr_n),
    .KeyMin_n(KeyMin_n),
    .AdjHr   (AdjHr),
    .AdjMin  (AdjMin),
    .Held    (Held)
  );

  initial begin
    CP = 1'b0;
    forever #5 CP = ~CP;
  end

  initial begin
    Tick1k = 1'b0;
    forever begin
      @(negedge CP);
      if (tick_en) begin
        div    = (div == 9) ? 0 : div + 1;
        Tick1k = (div == 9);
      end else begin
        Tick1k = 1'b0;
      end
    end
  end

  initial begin
    forever begin
      @(posedge CP);
      cyc++;
      if (Tick1k) tk++;
    end
  end

  task automatic chk(input string tag, input int obs, input int exp);
    total++;
    if (obs != exp) begin
      bad++;
      $display("FAIL %s: got %0d, want %0d (tick %0d)", tag, obs, exp, tk);
    end
  endtask

  // Pulse monitor: width check plus scoreboard pop.
  initial begin
    forever begin
      @(negedge CP);
      if (AdjHr) begin
        chk("hr_width", prev_hr, 0);
        if (exp_hr.size() == 0) chk("hr_extra_pulse_tick", tk, -1);
        else chk("hr_pulse_tick", tk, exp_hr.pop_front());
        hr_cyc = cyc;
      end
      if (AdjMin) begin
        chk("min_width", prev_min, 0);
        if (exp_min.size() == 0) chk("min_extra_pulse_tick", tk, -1);
        else chk("min_pulse_tick", tk, exp_min.pop_front());
        min_cyc = cyc;
      end
      prev_hr  = int'(AdjHr);
      prev_min = int'(AdjMin);
    end
  end

  task automatic align();
    @(posedge CP iff Tick1k);
    @(negedge CP);
  endtask

  task automatic wait_ticks(input int n);
    repeat (n) align();
  endtask

  task automatic push_held(input bit hr, input int t0, input int hold);
    exp_push(hr, t0 + 20);
`ifdef KEY_AUTO_REPEAT_EN
    for (int k = 520; k < hold; k += 100) exp_push(hr, t0 + k);
`endif
  endtask

  task automatic exp_push(input bit hr, input int t);
    if (hr) exp_hr.push_back(t);
    else exp_min.push_back(t);
  endtask

  task automatic chk_drained(input string tag);
    chk({tag, "_hr_missing"}, exp_hr.size(), 0);
    chk({tag, "_min_missing"}, exp_min.size(), 0);
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: run exceeded time limit at tick %0d", tk);
    $fatal(1, "watchdog");
  end

  initial begin
    CR       = 1'b1;
    KeyHr_n  = 1'b1;
    KeyMin_n = 1'b1;
    repeat (3) @(negedge CP);
    chk("rst_adjhr", int'(AdjHr), 0);
    chk("rst_adjmin", int'(AdjMin), 0);
    chk("rst_held", int'(Held), 0);
    CR = 1'b0;
    wait_ticks(2);

    // Short press: 15 ticks is below the debounce, no pulse.
    KeyMin_n = 1'b0;
    wait_ticks(15);
    chk("short_held", int'(Held), 0);
    KeyMin_n = 1'b1;
    wait_ticks(30);
    chk_drained("short");

    // Bouncy hour press held 300 ticks, bouncy release.
    for (int i = 0; i < 5; i++) begin
      KeyHr_n = i[0];
      if (i < 4) wait_ticks(1);
    end
    exp_push(1'b1, tk + 20);
    wait_ticks(300);
    chk("bounce_held", int'(Held), 1);
    for (int i = 0; i < 5; i++) begin
      KeyHr_n = ~i[0];
      if (i < 4) wait_ticks(1);
    end
    wait_ticks(30);
    chk("bounce_rel_held", int'(Held), 0);
    chk_drained("bounce");

    // Minute key held 1000 ticks.
    KeyMin_n = 1'b0;
    push_held(1'b0, tk, 1000);
    wait_ticks(25);
    chk("long_held", int'(Held), 1);
    wait_ticks(975);
    KeyMin_n = 1'b1;
    wait_ticks(30);
    chk("long_rel_held", int'(Held), 0);
    chk_drained("long");

    // Both keys in the same cycle, held 100 ticks.
    KeyHr_n  = 1'b0;
    KeyMin_n = 1'b0;
    exp_push(1'b1, tk + 20);
    exp_push(1'b0, tk + 20);
    wait_ticks(25);
    chk("both_same_cycle", hr_cyc, min_cyc);
    chk("both_held", int'(Held), 1);
    wait_ticks(75);
    KeyHr_n  = 1'b1;
    KeyMin_n = 1'b1;
    wait_ticks(30);
    chk("both_rel_held", int'(Held), 0);
    chk_drained("both");

    // Tick1k stopped: a long press must not confirm.
    tick_en = 1'b0;
    repeat (20) @(negedge CP);
    KeyMin_n = 1'b0;
    repeat (400) @(negedge CP);
    chk("notick_held", int'(Held), 0);
    KeyMin_n = 1'b1;
    repeat (20) @(negedge CP);
    tick_en = 1'b1;
    wait_ticks(5);
    chk_drained("notick");

    // Reset in the middle of a held press.
    KeyHr_n = 1'b0;
    exp_push(1'b1, tk + 20);
    wait_ticks(200);
    chk("prerst_held", int'(Held), 1);
    CR = 1'b1;
    #1;
    chk("midrst_held", int'(Held), 0);
    chk("midrst_adjhr", int'(AdjHr), 0);
    chk("midrst_adjmin", int'(AdjMin), 0);
    wait_ticks(1);
    CR = 1'b0;
    exp_push(1'b1, tk + 20);
    wait_ticks(25);
    chk("postrst_held", int'(Held), 1);
    wait_ticks(75);
    KeyHr_n = 1'b1;
    wait_ticks(30);
    chk("postrst_rel_held", int'(Held), 0);
    chk_drained("reset");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
